// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter FSM encoding and frame-length helper.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } tx_state_t;

    function automatic int unsigned frame_len(input int unsigned cpb,
                                              input int unsigned db,
                                              input int unsigned par,
                                              input int unsigned sb);
        return cpb * (1 + db + ((par != PAR_NONE) ? 1 : 0) + sb);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with show-ahead read data and occupancy count.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     i_Clock,
    input  logic                     i_Reset_n,
    input  logic                     i_Wr_En,
    input  logic [WIDTH-1:0]         i_Wr_Data,
    input  logic                     i_Rd_En,
    output logic [WIDTH-1:0]         o_Rd_Data,
    output logic [$clog2(DEPTH):0]   o_Count,
    output logic                     o_Full,
    output logic                     o_Empty
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             wr;
    logic             rd;

    assign wr        = i_Wr_En && !o_Full;
    assign rd        = i_Rd_En && !o_Empty;
    assign o_Full    = (o_Count == (PW+1)'(DEPTH));
    assign o_Empty   = (o_Count == '0);
    assign o_Rd_Data = mem[rd_ptr];

    always_ff @(posedge i_Clock) begin
        if (wr) mem[wr_ptr] <= i_Wr_Data;
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_Count <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + PW'(1);
            if (rd) rd_ptr <= rd_ptr + PW'(1);
            case ({wr, rd})
                2'b10:   o_Count <= o_Count + (PW+1)'(1);
                2'b01:   o_Count <= o_Count - (PW+1)'(1);
                default: o_Count <= o_Count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// Parametrised UART transmitter draining an internal FIFO into back-to-back frames.
module uart_tx_fifo_param
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset_n,
    input  logic                          i_Tx_DV,
    input  logic [DATA_BITS-1:0]          i_Tx_Byte,
    output logic                          o_Tx_Ready,
    output logic                          o_Overflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
    output logic                          o_Tx_Active,
    output logic                          o_Tx_Serial,
    output logic                          o_Tx_Done
);
    localparam int unsigned CNTW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDXW = $clog2(DATA_BITS);
    localparam logic [CNTW-1:0] CNT_LAST  = CNTW'(CLKS_PER_BIT - 1);
    localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(DATA_BITS - 1);
    localparam logic            STOP_LAST = 1'(STOP_BITS - 1);

    tx_state_t            state;
    logic [CNTW-1:0]      clk_cnt;
    logic [IDXW-1:0]      bit_idx;
    logic                 stop_cnt;
    logic [DATA_BITS-1:0] tx_data;
    logic                 par_bit;

    logic                 push;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_data;
    logic                 last_stop_clk;

    assign o_Tx_Ready    = !fifo_full;
    assign push          = i_Tx_DV && o_Tx_Ready;
    assign last_stop_clk = (state == S_STOP) && (clk_cnt == CNT_LAST) && (stop_cnt == STOP_LAST);
    assign pop           = !fifo_empty && ((state == S_IDLE) || last_stop_clk);

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_Clock   (i_Clock),
        .i_Reset_n (i_Reset_n),
        .i_Wr_En   (push),
        .i_Wr_Data (i_Tx_Byte),
        .i_Rd_En   (pop),
        .o_Rd_Data (fifo_data),
        .o_Count   (o_Fifo_Count),
        .o_Full    (fifo_full),
        .o_Empty   (fifo_empty)
    );

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) o_Overflow <= 1'b0;
        else            o_Overflow <= i_Tx_DV && !o_Tx_Ready;
    end

    // The line register follows the state by one clock, so a word popped in
    // IDLE shows its start bit one cycle later and each state lasts exactly
    // CLKS_PER_BIT line cycles.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state       <= S_IDLE;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            stop_cnt    <= 1'b0;
            tx_data     <= '0;
            par_bit     <= 1'b0;
            o_Tx_Serial <= 1'b1;
            o_Tx_Active <= 1'b0;
            o_Tx_Done   <= 1'b0;
        end else begin
            o_Tx_Done <= 1'b0;
            case (state)
                S_IDLE: begin
                    o_Tx_Serial <= 1'b1;
                    o_Tx_Active <= 1'b0;
                    if (pop) begin
                        tx_data <= fifo_data;
                        par_bit <= (PARITY == PAR_ODD) ? ~(^fifo_data) : ^fifo_data;
                        clk_cnt <= '0;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    o_Tx_Serial <= 1'b0;
                    o_Tx_Active <= 1'b1;
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt <= '0;
                        state   <= S_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + CNTW'(1);
                    end
                end
                S_DATA: begin
                    o_Tx_Serial <= tx_data[bit_idx];
                    o_Tx_Active <= 1'b1;
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt <= '0;
                        if (bit_idx == IDX_LAST) begin
                            bit_idx <= '0;
                            state   <= (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx <= bit_idx + IDXW'(1);
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNTW'(1);
                    end
                end
                S_PARITY: begin
                    o_Tx_Serial <= par_bit;
                    o_Tx_Active <= 1'b1;
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt <= '0;
                        state   <= S_STOP;
                    end else begin
                        clk_cnt <= clk_cnt + CNTW'(1);
                    end
                end
                S_STOP: begin
                    o_Tx_Serial <= 1'b1;
                    o_Tx_Active <= 1'b1;
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt <= '0;
                        if (stop_cnt == STOP_LAST) begin
                            stop_cnt  <= 1'b0;
                            o_Tx_Done <= 1'b1;
                            if (pop) begin
                                tx_data <= fifo_data;
                                par_bit <= (PARITY == PAR_ODD) ? ~(^fifo_data) : ^fifo_data;
                                state   <= S_START;
                            end else begin
                                state   <= S_IDLE;
                            end
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNTW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Directed scoreboard bench for uart_tx_fifo_param over four parameter sets.
module tb_uart_tx_fifo_param;
    import uart_pkg::*;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic [3:0] dv, ser, done, act, rdy, ovf;
    logic [3:0][2:0] cnt;
    logic [7:0] b0, b1, b2;
    logic [6:0] b3;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [7:0] w;
        logic       p;
    } exp_t;
    exp_t sbq[$];

    logic [7:0] ow [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    always #5 clk = ~clk;

    uart_tx_fifo_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Tx_DV(dv[0]), .i_Tx_Byte(b0), .o_Tx_Ready(rdy[0]),
        .o_Overflow(ovf[0]), .o_Fifo_Count(cnt[0]), .o_Tx_Active(act[0]), .o_Tx_Serial(ser[0]), .o_Tx_Done(done[0]));
    uart_tx_fifo_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Tx_DV(dv[1]), .i_Tx_Byte(b1), .o_Tx_Ready(rdy[1]),
        .o_Overflow(ovf[1]), .o_Fifo_Count(cnt[1]), .o_Tx_Active(act[1]), .o_Tx_Serial(ser[1]), .o_Tx_Done(done[1]));
    uart_tx_fifo_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Tx_DV(dv[2]), .i_Tx_Byte(b2), .o_Tx_Ready(rdy[2]),
        .o_Overflow(ovf[2]), .o_Fifo_Count(cnt[2]), .o_Tx_Active(act[2]), .o_Tx_Serial(ser[2]), .o_Tx_Done(done[2]));
    uart_tx_fifo_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u3 (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Tx_DV(dv[3]), .i_Tx_Byte(b3), .o_Tx_Ready(rdy[3]),
        .o_Overflow(ovf[3]), .o_Fifo_Count(cnt[3]), .o_Tx_Active(act[3]), .o_Tx_Serial(ser[3]), .o_Tx_Done(done[3]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input logic v, input logic [7:0] w);
        dv[d] = v;
        case (d)
            0:       b0 = w;
            1:       b1 = w;
            2:       b2 = w;
            default: b3 = w[6:0];
        endcase
    endtask

    task automatic expect_word(input logic [7:0] w, input logic p);
        exp_t e;
        e.w = w;
        e.p = p;
        sbq.push_back(e);
    endtask

    // c0 > 0: the caller is already c0 cycles into the frame; exp_gap < 0: gap unchecked.
    task automatic capture(input int d, input int db, input int par, input int sb,
                           input int c0, input int exp_gap, input bit tail, input string tag);
        int L, n, slot, ph, pbits, dones, done_at, act_lo, stop_hi;
        logic [7:0] got, mask;
        logic pb, st;
        exp_t e;
        L = int'(frame_len(CPB, db, par, sb));
        pbits = (par != 0) ? 1 : 0;
        dones = 0; done_at = -1; act_lo = 0; stop_hi = 0;
        got = '0; pb = 1'b0; st = 1'b1;
        if (c0 == 0) begin
            n = 0;
            while (ser[d] !== 1'b0 && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk({tag, ".fall_seen"}, 32'(ser[d]), 32'd0);
            if (ser[d] !== 1'b0) return;
            if (exp_gap >= 0) chk({tag, ".gap"}, n, exp_gap);
        end
        for (int c = c0; c < L; c++) begin
            if (c != c0) @(negedge clk);
            slot = c / CPB;
            ph = c % CPB;
            if (ph == CPB / 2) begin
                if (slot == 0) st = ser[d];
                else if (slot <= db) got[slot-1] = ser[d];
                else if (pbits == 1 && slot == db + 1) pb = ser[d];
            end
            if (slot >= 1 + db + pbits && ser[d] === 1'b1) stop_hi++;
            if (done[d] === 1'b1) begin
                dones++;
                done_at = c;
            end
            if (act[d] !== 1'b1) act_lo++;
        end
        chk({tag, ".sb_nonempty"}, 32'(sbq.size() != 0), 32'd1);
        if (sbq.size() == 0) return;
        e = sbq.pop_front();
        mask = 8'((1 << db) - 1);
        if (c0 <= CPB / 2) chk({tag, ".start"}, 32'(st), 32'd0);
        chk({tag, ".data"}, 32'(got & mask), 32'(e.w & mask));
        if (pbits == 1) chk({tag, ".parity"}, 32'(pb), 32'(e.p));
        chk({tag, ".stop_cycles"}, stop_hi, sb * CPB);
        chk({tag, ".done_count"}, dones, 1);
        chk({tag, ".done_cycle"}, done_at, L - 1);
        chk({tag, ".active_low"}, act_lo, 0);
        if (tail) begin
            @(negedge clk);
            chk({tag, ".tail_ser"}, 32'(ser[d]), 32'd1);
            chk({tag, ".tail_act"}, 32'(act[d]), 32'd0);
            chk({tag, ".tail_done"}, 32'(done[d]), 32'd0);
            chk({tag, ".tail_cnt"}, 32'(cnt[d]), 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lo, dn;
        rst_n = 1'b0;
        dv = '0;
        b0 = '0; b1 = '0; b2 = '0; b3 = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("rst%0d.ser", d),  32'(ser[d]),  32'd1);
            chk($sformatf("rst%0d.act", d),  32'(act[d]),  32'd0);
            chk($sformatf("rst%0d.done", d), 32'(done[d]), 32'd0);
            chk($sformatf("rst%0d.ovf", d),  32'(ovf[d]),  32'd0);
            chk($sformatf("rst%0d.cnt", d),  32'(cnt[d]),  32'd0);
            chk($sformatf("rst%0d.rdy", d),  32'(rdy[d]),  32'd1);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // 8N1 single word, latency and frame shape
        expect_word(8'h55, 1'b0);
        drive(0, 1'b1, 8'h55);
        @(negedge clk);
        drive(0, 1'b0, 8'hAA);
        capture(0, 8, 0, 1, 0, 2, 1'b1, "8n1_55");

        // parity modes
        expect_word(8'h07, 1'b1);
        drive(1, 1'b1, 8'h07);
        @(negedge clk);
        drive(1, 1'b0, 8'hFF);
        capture(1, 8, 2, 1, 0, 2, 1'b1, "even_07");
        expect_word(8'h03, 1'b0);
        drive(1, 1'b1, 8'h03);
        @(negedge clk);
        drive(1, 1'b0, 8'hFF);
        capture(1, 8, 2, 1, 0, 2, 1'b1, "even_03");
        expect_word(8'h00, 1'b1);
        drive(2, 1'b1, 8'h00);
        @(negedge clk);
        drive(2, 1'b0, 8'hFF);
        capture(2, 8, 1, 1, 0, 2, 1'b1, "odd_00");

        // 7 data bits, two stop bits
        expect_word(8'h7F, 1'b0);
        drive(3, 1'b1, 8'h7F);
        @(negedge clk);
        drive(3, 1'b0, 8'h00);
        capture(3, 7, 0, 2, 0, 2, 1'b1, "7n2_7f");

        // three contiguous frames
        expect_word(8'hA1, 1'b0);
        drive(0, 1'b1, 8'hA1);
        @(negedge clk);
        expect_word(8'hB2, 1'b0);
        drive(0, 1'b1, 8'hB2);
        @(negedge clk);
        expect_word(8'hC3, 1'b0);
        drive(0, 1'b1, 8'hC3);
        @(negedge clk);
        drive(0, 1'b0, 8'h00);
        chk("b2b.cnt_after_push", 32'(cnt[0]), 32'd2);
        capture(0, 8, 0, 1, 0, 0, 1'b0, "b2b_a1");
        capture(0, 8, 0, 1, 0, 1, 1'b0, "b2b_b2");
        capture(0, 8, 0, 1, 0, 1, 1'b1, "b2b_c3");

        // overflow: sixth word dropped while full
        for (int i = 0; i < 6; i++) begin
            drive(0, 1'b1, ow[i]);
            if (i < 5) expect_word(ow[i], 1'b0);
            chk($sformatf("ovf.rdy%0d", i), 32'(rdy[0]), 32'(i < 5));
            chk($sformatf("ovf.pulse_pre%0d", i), 32'(ovf[0]), 32'd0);
            if (i == 5) chk("ovf.cnt_full", 32'(cnt[0]), 32'd4);
            @(negedge clk);
        end
        drive(0, 1'b0, 8'h00);
        chk("ovf.pulse", 32'(ovf[0]), 32'd1);
        chk("ovf.cnt_kept", 32'(cnt[0]), 32'd4);
        @(negedge clk);
        chk("ovf.pulse_end", 32'(ovf[0]), 32'd0);
        capture(0, 8, 0, 1, 4, -1, 1'b0, "ovf_f0");
        for (int i = 1; i < 5; i++)
            capture(0, 8, 0, 1, 0, 1, i == 4, $sformatf("ovf_f%0d", i));

        // reset in the middle of DATA with two words queued
        drive(0, 1'b1, 8'h81);
        @(negedge clk);
        drive(0, 1'b1, 8'h42);
        @(negedge clk);
        drive(0, 1'b1, 8'h24);
        @(negedge clk);
        drive(0, 1'b0, 8'h00);
        chk("rmid.fall", 32'(ser[0]), 32'd0);
        chk("rmid.cnt", 32'(cnt[0]), 32'd2);
        repeat (3 * CPB + 1) @(negedge clk);
        chk("rmid.active", 32'(act[0]), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rmid.async_ser", 32'(ser[0]), 32'd1);
        chk("rmid.async_act", 32'(act[0]), 32'd0);
        chk("rmid.async_cnt", 32'(cnt[0]), 32'd0);
        chk("rmid.async_done", 32'(done[0]), 32'd0);
        chk("rmid.async_rdy", 32'(rdy[0]), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        lo = 0;
        dn = 0;
        repeat (80) begin
            @(negedge clk);
            if (ser[0] !== 1'b1) lo++;
            if (done[0] !== 1'b0) dn++;
        end
        chk("rpost.line_low_cycles", lo, 0);
        chk("rpost.done_pulses", dn, 0);
        chk("rpost.cnt", 32'(cnt[0]), 32'd0);
        chk("sb.drained", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
